// File: rtl/sram_kn_pkg.sv
// Shared types and width helpers for the k-major SRAM scheduler.
//   calc_k_w / calc_n_w : index widths derived from KMAX / N
//   sched_state_e       : sequencer FSM states
//   rd_tag_t            : {k, n, last} tag that travels with each read
package sram_kn_pkg;

    function automatic int unsigned calc_k_w(input int unsigned kmax);
        return (kmax <= 32'd1) ? 32'd1 : 32'($clog2(kmax));
    endfunction

    function automatic int unsigned calc_n_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    localparam int unsigned DEF_KMAX   = 1024;
    localparam int unsigned DEF_N      = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_FIFO_D = 2;
    localparam int unsigned DEF_K_W    = calc_k_w(DEF_KMAX);
    localparam int unsigned DEF_N_W    = calc_n_w(DEF_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [DEF_K_W-1:0] k;
        logic [DEF_N_W-1:0] n;
        logic               last;
    } rd_tag_t;

endpackage

// File: rtl/sram_kn_fifo.sv
// Small synchronous FIFO holding returned read data plus its tag.
//   push/push_data : write side (ignored when full)
//   pop            : read side (ignored when empty)
//   head/valid     : current head entry and non-empty flag
//   count          : occupancy, used by the scheduler for credits
module sram_kn_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH <= 32'd1) ? 32'd1 : 32'($clog2(DEPTH));

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign valid   = (count != '0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_kn_sched.sv
// Scheduler/arbiter in front of a single-port k-major SRAM.
//   wr_*   : host write requester, granted combinationally via wr_ready
//   cfg_*  : stream programming (start pulse, base row, row count)
//   rd_*   : valid/ready element stream to the MAC array (k outer, n inner)
//   x_*    : SRAM port; read data returns one cycle after x_re with x_rvalid
//   busy/done : stream status; done pulses once when a stream completes
module sram_kn_sched
    import sram_kn_pkg::*;
#(
    parameter int unsigned KMAX   = DEF_KMAX,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BYTE_W = DATA_W / 8,
    parameter int unsigned K_W    = calc_k_w(KMAX),
    parameter int unsigned N_W    = calc_n_w(N),
    parameter int unsigned FIFO_D = DEF_FIFO_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [K_W-1:0]    wr_k,
    input  logic [N_W-1:0]    wr_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BYTE_W-1:0] wr_mask,
    input  logic              cfg_start,
    input  logic [K_W-1:0]    cfg_k_base,
    input  logic [K_W:0]      cfg_k_len,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [K_W-1:0]    rd_k,
    output logic [N_W-1:0]    rd_n,
    output logic              rd_last,
    output logic              x_en,
    output logic              x_re,
    output logic              x_we,
    output logic [K_W-1:0]    x_k,
    output logic [N_W-1:0]    x_n,
    output logic [DATA_W-1:0] x_wdata,
    output logic [BYTE_W-1:0] x_wmask,
    input  logic [DATA_W-1:0] x_rdata,
    input  logic              x_rvalid
);

    localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
    localparam int unsigned TAG_W = $bits(rd_tag_t);
    localparam int unsigned ENT_W = DATA_W + TAG_W;

    sched_state_e      state;
    logic [K_W-1:0]    seq_k;
    logic [N_W-1:0]    seq_n;
    logic [K_W:0]      rows_left;
    logic              inflight;
    rd_tag_t           pend_tag;
    logic              rr_wr_first;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_valid;
    logic [ENT_W-1:0]  fifo_head;
    logic [ENT_W-1:0]  push_ent;
    rd_tag_t           head_tag;

    logic [CNT_W:0]    used;
    logic              wr_req;
    logic              rd_req;
    logic              wr_grant;
    logic              rd_grant;
    logic              seq_last;
    logic              push;
    logic              pop;
    logic              drain_done;

    // Credit: FIFO slots not yet claimed by buffered or in-flight reads
    assign used   = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
    assign rd_req = (state == ISSUE) && (used < (CNT_W+1)'(FIFO_D));

    // Writes are never granted while reset is held
    assign wr_req = wr_valid && !rst;

    // Round-robin only matters when both sides request
    assign wr_grant = wr_req && (!rd_req || rr_wr_first);
    assign rd_grant = rd_req && !wr_grant;

    assign seq_last = (rows_left == (K_W+1)'(1)) && (seq_n == N_W'(N - 1));

    // A return without an outstanding read is dropped
    assign push = x_rvalid && inflight;
    assign pop  = fifo_valid && rd_ready;

    // Leave DRAIN on the cycle the final element is handed off
    assign drain_done = (state == DRAIN) && !inflight &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    // Memory port drive
    always_comb begin
        wr_ready = wr_grant;
        x_en     = wr_grant || rd_grant;
        x_we     = wr_grant;
        x_re     = rd_grant;
        x_k      = '0;
        x_n      = '0;
        x_wdata  = '0;
        x_wmask  = '0;
        if (wr_grant) begin
            x_k     = wr_k;
            x_n     = wr_n;
            x_wdata = wr_data;
            x_wmask = wr_mask;
        end else if (rd_grant) begin
            x_k = seq_k;
            x_n = seq_n;
        end
    end

    // Sequencer FSM, arbitration pointer and read tag tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            seq_k       <= '0;
            seq_n       <= '0;
            rows_left   <= '0;
            inflight    <= 1'b0;
            pend_tag    <= '0;
            rr_wr_first <= 1'b1;
        end else begin
            done <= 1'b0;

            if (wr_req && rd_req) begin
                rr_wr_first <= !rr_wr_first;
            end

            if (rd_grant) begin
                inflight <= 1'b1;
                pend_tag <= '{k: seq_k, n: seq_n, last: seq_last};
            end else if (x_rvalid) begin
                inflight <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_k_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            seq_k     <= cfg_k_base;
                            seq_n     <= '0;
                            rows_left <= cfg_k_len;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_grant) begin
                        if (seq_last) begin
                            state <= DRAIN;
                        end else if (seq_n == N_W'(N - 1)) begin
                            seq_n     <= '0;
                            seq_k     <= seq_k + K_W'(1);
                            rows_left <= rows_left - (K_W+1)'(1);
                        end else begin
                            seq_n <= seq_n + N_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign push_ent = {x_rdata, pend_tag};

    sram_kn_fifo #(
        .DEPTH (FIFO_D),
        .W     (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign {rd_data, head_tag} = fifo_head;
    assign rd_valid = fifo_valid;
    assign rd_k     = head_tag.k;
    assign rd_n     = head_tag.n;
    assign rd_last  = head_tag.last;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst) x_rvalid |-> inflight);
    a_one_op:          assert property (@(posedge clk) disable iff (rst) !(x_re && x_we));

endmodule

// File: tb/tb_sram_kn_sched.sv
module tb_sram_kn_sched;

    localparam int unsigned KMAX   = 1024;
    localparam int unsigned N      = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 4;
    localparam int unsigned K_W    = 10;
    localparam int unsigned N_W    = 3;
    localparam int unsigned FIFO_D = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [K_W-1:0]    wr_k;
    logic [N_W-1:0]    wr_n;
    logic [DATA_W-1:0] wr_data;
    logic [BYTE_W-1:0] wr_mask;
    logic              cfg_start;
    logic [K_W-1:0]    cfg_k_base;
    logic [K_W:0]      cfg_k_len;
    logic              busy;
    logic              done;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [K_W-1:0]    rd_k;
    logic [N_W-1:0]    rd_n;
    logic              rd_last;
    logic              x_en, x_re, x_we;
    logic [K_W-1:0]    x_k;
    logic [N_W-1:0]    x_n;
    logic [DATA_W-1:0] x_wdata;
    logic [BYTE_W-1:0] x_wmask;
    logic [DATA_W-1:0] x_rdata;
    logic              x_rvalid;

    sram_kn_sched #(
        .KMAX(KMAX), .N(N), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
        .K_W(K_W), .N_W(N_W), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_k(wr_k), .wr_n(wr_n),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .cfg_start(cfg_start), .cfg_k_base(cfg_k_base), .cfg_k_len(cfg_k_len),
        .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_k(rd_k), .rd_n(rd_n), .rd_last(rd_last),
        .x_en(x_en), .x_re(x_re), .x_we(x_we), .x_k(x_k), .x_n(x_n),
        .x_wdata(x_wdata), .x_wmask(x_wmask),
        .x_rdata(x_rdata), .x_rvalid(x_rvalid)
    );

    always #5 clk = ~clk;

    // SRAM model (driven by x_*) and golden host-view memory (driven by wr_* handshakes)
    logic [DATA_W-1:0] mem  [KMAX][N];
    logic [DATA_W-1:0] gold [KMAX][N];
    bit                mem_ready;

    function automatic logic [DATA_W-1:0] seed_word(input int k, input int n);
        return DATA_W'(32'hA500_0000 | (k << 8) | n);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < int'(KMAX); k++)
                for (int n = 0; n < int'(N); n++) begin
                    mem[k][n]  <= seed_word(k, n);
                    gold[k][n]  = seed_word(k, n);
                end
            mem_ready <= 1'b1;
        end
        x_rvalid <= 1'b0;
        if (x_en && x_we)
            for (int b = 0; b < int'(BYTE_W); b++)
                if (x_wmask[b]) mem[x_k][x_n][8*b +: 8] <= x_wdata[8*b +: 8];
        if (x_en && x_re) begin
            x_rdata  <= mem[x_k][x_n];
            x_rvalid <= 1'b1;
        end
        if (wr_valid && wr_ready)
            for (int b = 0; b < int'(BYTE_W); b++)
                if (wr_mask[b]) gold[wr_k][wr_n][8*b +: 8] = wr_data[8*b +: 8];
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [K_W-1:0]    k;
        logic [N_W-1:0]    n;
        logic              last;
    } elem_t;

    typedef struct {
        logic [K_W-1:0] base;
        logic [K_W:0]   len;
        int             ready_mode;
        int             exp_elems;
        logic [K_W-1:0] exp_first_k;
        logic [K_W-1:0] exp_last_k;
    } vec_t;

    elem_t             exp_q[$];
    int                vectors = 0;
    int                fails   = 0;
    int                rx_count, done_cnt, re_cnt, we_cnt;
    bit                busy_model, exp_done, prev_xre, alt_mode, last_wr_ready;
    logic [K_W-1:0]    first_k, last_k;
    logic [DATA_W-1:0] first_data, last_data;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle observation at the falling edge
    task automatic monitor();
        elem_t e;
        bit    nd;
        if (rst) begin
            exp_q.delete();
            busy_model = 0;
            exp_done   = 0;
            prev_xre   = 0;
            return;
        end
        check("re_we_exclusive", 64'(x_re && x_we), 64'd0);
        check("wr_ready_eq_we",  64'(wr_ready), 64'(x_we));
        check("done",            64'(done), 64'(exp_done));
        check("busy",            64'(busy), 64'(busy_model));
        if (alt_mode) begin
            check("alt_we_or_re", 64'(x_we), 64'(!x_re));
            if (x_re) check("alt_no_back2back_re", 64'(prev_xre), 64'd0);
        end
        nd = 0;
        if (cfg_start && !busy_model) begin
            if (cfg_k_len == '0) nd = 1;
            else busy_model = 1;
        end
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_element", 64'(rd_k), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(e.data));
                check("rd_k",    64'(rd_k),    64'(e.k));
                check("rd_n",    64'(rd_n),    64'(e.n));
                check("rd_last", 64'(rd_last), 64'(e.last));
                if (rx_count == 0) begin
                    first_k    = rd_k;
                    first_data = rd_data;
                end
                last_k    = rd_k;
                last_data = rd_data;
                rx_count++;
                if (e.last) begin
                    nd = 1;
                    busy_model = 0;
                end
            end
        end
        if (done) done_cnt++;
        if (x_re) re_cnt++;
        if (x_we) we_cnt++;
        last_wr_ready = wr_ready;
        exp_done = nd;
        prev_xre = x_re;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     64'(busy),     0);
        check({tag, "_done"},     64'(done),     0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 0);
        check({tag, "_rd_last"},  64'(rd_last),  0);
        check({tag, "_rd_data"},  64'(rd_data),  0);
        check({tag, "_rd_k"},     64'(rd_k),     0);
        check({tag, "_rd_n"},     64'(rd_n),     0);
        check({tag, "_x_en"},     64'(x_en),     0);
        check({tag, "_x_re"},     64'(x_re),     0);
        check({tag, "_x_we"},     64'(x_we),     0);
        check({tag, "_x_k"},      64'(x_k),      0);
        check({tag, "_x_n"},      64'(x_n),      0);
        check({tag, "_x_wdata"},  64'(x_wdata),  0);
        check({tag, "_x_wmask"},  64'(x_wmask),  0);
        check({tag, "_wr_ready"}, 64'(wr_ready), 0);
    endtask

    task automatic do_write(input int k, input int n, input logic [DATA_W-1:0] d, input logic [BYTE_W-1:0] m);
        bit g = 0;
        wr_valid = 1; wr_k = K_W'(k); wr_n = N_W'(n); wr_data = d; wr_mask = m;
        for (int c = 0; c < 20 && !g; c++) begin
            tick();
            g = last_wr_ready;
        end
        wr_valid = 0;
        check("wr_grant_timeout", 64'(g), 64'd1);
    endtask

    // Expected stream built from the golden memory: k outer with wrap, n inner
    task automatic start_stream(input logic [K_W-1:0] base, input logic [K_W:0] len, input bit accept);
        elem_t e;
        int    kk;
        if (accept) begin
            rx_count = 0;
            for (int i = 0; i < int'(len); i++)
                for (int n = 0; n < int'(N); n++) begin
                    kk     = (int'(base) + i) % int'(KMAX);
                    e.k    = K_W'(kk);
                    e.n    = N_W'(n);
                    e.data = gold[kk][n];
                    e.last = (i == int'(len) - 1) && (n == int'(N) - 1);
                    exp_q.push_back(e);
                end
        end
        cfg_start = 1; cfg_k_base = base; cfg_k_len = len;
        tick();
        cfg_start  = 0;
        cfg_k_base = K_W'($urandom);
        cfg_k_len  = (K_W+1)'($urandom);
    endtask

    task automatic run_to_done(input int mode, input int maxcyc);
        int d0 = done_cnt;
        bit ok = 0;
        for (int c = 0; c < maxcyc; c++) begin
            case (mode)
                0:       rd_ready = 1;
                1:       rd_ready = ($urandom_range(0, 3) != 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        check("done_timeout", 64'(ok), 64'd1);
        rd_ready = 1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t tbl[5];

    initial begin
        int re0, rx0, we0, d0, buffered, base_r, len_r;

        rst = 1; wr_valid = 0; wr_k = '0; wr_n = '0; wr_data = '0; wr_mask = '0;
        cfg_start = 0; cfg_k_base = '0; cfg_k_len = '0; rd_ready = 1;
        rx_count = 0; done_cnt = 0; re_cnt = 0; we_cnt = 0; alt_mode = 0;

        tbl[0] = '{10'd3,    11'd1, 0,  8, 10'd3,    10'd3};
        tbl[1] = '{10'd1023, 11'd2, 0, 16, 10'd1023, 10'd0};
        tbl[2] = '{10'd100,  11'd3, 1, 24, 10'd100,  10'd102};
        tbl[3] = '{10'd1021, 11'd5, 2, 40, 10'd1021, 10'd1};
        tbl[4] = '{10'd7,    11'd0, 0,  0, 10'd0,    10'd0};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        for (int n = 0; n < int'(N); n++) do_write(3, n, DATA_W'(32'h30 + n), 4'hF);

        // Table-driven streams
        for (int t = 0; t < 5; t++) begin
            start_stream(tbl[t].base, tbl[t].len, 1'b1);
            rx_count = 0;
            run_to_done(tbl[t].ready_mode, 400);
            check($sformatf("tbl%0d_count", t), 64'(rx_count), 64'(tbl[t].exp_elems));
            if (tbl[t].exp_elems > 0) begin
                check($sformatf("tbl%0d_first_k", t), 64'(first_k), 64'(tbl[t].exp_first_k));
                check($sformatf("tbl%0d_last_k", t),  64'(last_k),  64'(tbl[t].exp_last_k));
            end
            if (t == 0) begin
                check("tbl0_first_data", 64'(first_data), 64'h30);
                check("tbl0_last_data",  64'(last_data),  64'h37);
            end
            repeat (2) tick();
        end

        // Backpressure: consumer stalls for 20 cycles mid-stream
        start_stream(10'd200, 11'd3, 1'b1);
        rx_count = 0;
        re0 = re_cnt;
        repeat (4) tick();
        rd_ready = 0;
        rx0 = rx_count;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) we0 = re_cnt;
            tick();
        end
        check("bp_no_reads_while_full", 64'(re_cnt - we0), 64'd0);
        check("bp_no_pop_while_stalled", 64'(rx_count), 64'(rx0));
        buffered = (re_cnt - re0) - rx_count;
        check("bp_buffered_le_depth", 64'(buffered <= int'(FIFO_D)), 64'd1);
        run_to_done(0, 200);
        check("bp_count", 64'(rx_count), 64'd24);
        repeat (2) tick();

        // Write requester held active during a stream
        wr_valid = 1; wr_k = 10'd562; wr_n = 3'd5; wr_data = 32'hDEAD_BEEF; wr_mask = 4'hF;
        alt_mode = 1;
        re0 = re_cnt; we0 = we_cnt;
        start_stream(10'd50, 11'd2, 1'b1);
        rx_count = 0;
        run_to_done(0, 200);
        alt_mode = 0;
        wr_valid = 0;
        check("alt_count", 64'(rx_count), 64'd16);
        check("alt_reads", 64'(re_cnt - re0), 64'd16);
        check("alt_writes_interleaved", 64'((we_cnt - we0) >= 15), 64'd1);
        repeat (2) tick();

        // Start while busy is ignored
        start_stream(10'd300, 11'd2, 1'b1);
        rx_count = 0;
        repeat (3) tick();
        start_stream(10'd5, 11'd7, 1'b0);
        run_to_done(0, 200);
        check("busy_start_ignored", 64'(rx_count), 64'd16);
        repeat (3) tick();
        check("busy_start_no_extra", 64'(rx_count), 64'd16);

        // Reset in the middle of ISSUE
        start_stream(10'd400, 11'd4, 1'b1);
        repeat (5) tick();
        d0 = done_cnt;
        rst = 1;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;
        tick();
        rst = 0;
        exp_q.delete();
        repeat (5) tick();
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        start_stream(10'd3, 11'd1, 1'b1);
        rx_count = 0;
        run_to_done(0, 200);
        check("midrst_restart_count", 64'(rx_count), 64'd8);
        check("midrst_restart_first", 64'(first_data), 64'h30);
        repeat (2) tick();

        // Randomized streams with random pre-writes and random consumer stalls
        for (int r = 0; r < 8; r++) begin
            base_r = int'($urandom_range(0, KMAX - 1));
            len_r  = int'($urandom_range(1, 4));
            for (int w = 0; w < 4; w++)
                do_write((base_r + int'($urandom_range(0, len_r - 1))) % int'(KMAX),
                         int'($urandom_range(0, N - 1)), $urandom, 4'($urandom_range(1, 15)));
            start_stream(K_W'(base_r), (K_W+1)'(len_r), 1'b1);
            rx_count = 0;
            run_to_done(1 + (r % 2), 600);
            check($sformatf("rand%0d_count", r), 64'(rx_count), 64'(len_r * int'(N)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
